linear_regression_training: RTL
===============================

# linear_regression_training

Batch least-squares trainer: accepts K (x, y) sample pairs, fits y = theta1·x + theta0 with a sequential signed divider, and publishes the coefficients on the theta0/theta1 interface consumed by the prediction block. Sits upstream of prediction. Thetas stay valid and stable while the next batch trains and update atomically when it completes.

## Interface
- N, default 32: sample and theta width.
- K, default 16: samples per batch. Must be a power of two, ≥2. Derived localparam KW = log2(K).
- i_clock  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_samples_x_in  in  N  sample x, unsigned.
- i_samples_y_in  in  N  sample y, unsigned.
- i_samples_vld  in  1  sample pair valid.
- o_samples_rdy  out  1  trainer accepting samples (reset 1).
- o_theta0_out  out  N  intercept, signed two's complement (reset 0).
- o_theta1_out  out  N  slope, signed two's complement (reset 0).
- o_theta1_out_vld  out  1  thetas valid. Level signal; reset 0; set at first commit; stays 1 until reset (reset 0).
- o_train_done  out  1  one-cycle pulse on each commit (reset 0).
- o_degenerate  out  1  last commit had zero denominator; updated at each commit (reset 0).

## Operation
- States: ACCUM (reset state), CALC, DIV, FINISH.
- ACCUM:
  - o_samples_rdy=1.
  - Each cycle with i_samples_vld=1 accepts one pair.
  - Accumulators updated: Sx (N+KW bits), Sy (N+KW), Sxy (2N+KW), Sxx (2N+KW), and a sample count.
  - On the K-th accept, go to CALC.
- CALC:
  - Register NUM = K·Sxy − Sx·Sy, signed, width W = 2N+2KW+1.
  - Register DEN = K·Sxx − Sx², unsigned, width 2N+2KW.
  - Multiplication by K is a left shift by KW.
  - If DEN==0, go to FINISH with quotient forced to 0. Otherwise go to DIV.
- DIV:
  - Restoring division of |NUM| by DEN, one quotient bit per cycle, exactly W cycles.
  - Quotient sign = sign of NUM. Rounding truncates toward zero.
- FINISH:
  - theta1 = quotient reduced to N signed bits (see Configuration).
  - theta0 = (Sy − theta1·Sx) >>> KW, using arithmetic shift on a full-width signed product. Reduced to N signed bits the same way.
  - Commit o_theta0_out, o_theta1_out and o_degenerate together. Set o_theta1_out_vld=1. Pulse o_train_done.
  - Clear accumulators and go to ACCUM.
- Outside ACCUM: o_samples_rdy=0, and i_samples_vld is ignored (no sample is stored).
- Published thetas change only in FINISH. Prediction may keep using old thetas throughout a retrain.
- Reset at any point, including mid-DIV:
  - All outputs return to reset values.
  - Accumulators and divider state are cleared; state returns to ACCUM.
  - The partial batch is discarded.

## Timing
- Let E0 be the edge that accepts the K-th sample.
- Nondegenerate batch:
  - E1: CALC registers NUM and DEN.
  - E2..E(W+1): divide iterations.
  - E(W+2): FINISH commit. New thetas and o_train_done visible after E(W+2).
- Degenerate batch (DEN==0): commit at E2.
- o_samples_rdy returns to 1 the cycle after commit.
- First sample of the next batch can be accepted at edge E(W+3), or E3 for a degenerate batch.
- Throughput: one sample per cycle in ACCUM. Minimum batch period K+W+2 cycles.

## Configuration
- LR_TRAIN_SAT_EN defined: theta0 and theta1 saturate to [−2^(N−1), 2^(N−1)−1] when the full-precision value is out of range.
- LR_TRAIN_SAT_EN undefined: values wrap, keeping the low N bits.
- Saturation of theta1 is applied before theta0 is computed. theta0 always uses the published theta1.

## Test plan
- Line fit, N=32, K=16: x=0..15, y=2x+3 -> o_theta1_out=2, o_theta0_out=3, o_degenerate=0; o_train_done pulses once, W+2 edges after the 16th accept.
- Negative slope: x=0..15, y=100−x -> o_theta1_out=0xFFFFFFFF, o_theta0_out=100.
- Degenerate: all x=5, y=10..25 -> o_theta1_out=0, o_theta0_out=17 (mean 17.5 truncated), o_degenerate=1; commit at E2.
- Saturation:
  - Stimulus: 8×(x=0, y=0), then 8×(x=1, y=0xFFFFFFFF).
  - With LR_TRAIN_SAT_EN -> theta1=0x7FFFFFFF, theta0=0x40000000.
  - Without LR_TRAIN_SAT_EN -> theta1=0xFFFFFFFF, theta0=0x80000000.
- Backpressure and retrain:
  - Hold i_samples_vld=1 through CALC/DIV -> o_samples_rdy=0 and nothing is accumulated.
  - Old thetas stay stable with vld=1 until the second batch commits.
- Reset mid-DIV: assert i_reset=0 at E10 -> all outputs 0, o_samples_rdy=1. A fresh full batch afterwards produces correct thetas.

Source files
------------

// File: rtl/linear_regression_training.sv
// linear_regression_training: batch least-squares fit of y = theta1*x + theta0
// over K unsigned (x, y) pairs, using a W-cycle restoring signed divider.
//
// Ports:
//   i_clock, i_reset (async, active-low)
//   i_samples_x_in/i_samples_y_in/i_samples_vld : sample pair input
//   o_samples_rdy    : high while accumulating (ACCUM)
//   o_theta0_out     : intercept, signed N bits
//   o_theta1_out     : slope, signed N bits
//   o_theta1_out_vld : thetas valid since the first commit
//   o_train_done     : one-cycle pulse per commit
//   o_degenerate     : last commit had a zero denominator
//
// Optional: define LR_TRAIN_SAT_EN to saturate thetas to N signed bits
// instead of keeping the low N bits.

module linear_regression_training #(
    parameter int N = 32,
    parameter int K = 16
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic [N-1:0] i_samples_x_in,
    input  logic [N-1:0] i_samples_y_in,
    input  logic         i_samples_vld,
    output logic         o_samples_rdy,
    output logic [N-1:0] o_theta0_out,
    output logic [N-1:0] o_theta1_out,
    output logic         o_theta1_out_vld,
    output logic         o_train_done,
    output logic         o_degenerate
);

    localparam int KW = $clog2(K);
    localparam int AW = N + KW;
    localparam int MW = 2 * N + KW;
    localparam int P  = 2 * N + 2 * KW;
    localparam int W  = P + 1;
    localparam int LW = W + 1;
    localparam int CW = $clog2(W);

    localparam logic signed [LW-1:0] MAXV =
        {{(LW-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [LW-1:0] MINV =
        {{(LW-N+1){1'b1}}, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        ACCUM,
        CALC,
        DIV,
        FINISH
    } state_t;

    state_t state_q, state_d;

    logic [AW-1:0] sx_q, sx_d;
    logic [AW-1:0] sy_q, sy_d;
    logic [MW-1:0] sxy_q, sxy_d;
    logic [MW-1:0] sxx_q, sxx_d;
    logic [KW-1:0] cnt_q, cnt_d;

    logic [P-1:0]  den_q, den_d;
    logic          neg_q, neg_d;
    logic [W-1:0]  dq_q, dq_d;
    logic [W-2:0]  rem_q, rem_d;
    logic [CW-1:0] dcnt_q, dcnt_d;

    logic [N-1:0]  theta0_q, theta0_d;
    logic [N-1:0]  theta1_q, theta1_d;
    logic          vld_q, vld_d;
    logic          done_q, done_d;
    logic          deg_q, deg_d;

    // Narrow a wide signed value to N bits: saturate or wrap.
    function automatic logic [N-1:0] reduce(
        input logic signed [LW-1:0] v
    );
`ifdef LR_TRAIN_SAT_EN
        if (v > MAXV) return {1'b0, {(N-1){1'b1}}};
        if (v < MINV) return {1'b1, {(N-1){1'b0}}};
`endif
        return N'(v);
    endfunction

    // Sample products and batch sums.
    logic [2*N-1:0] xy, xx;
    logic [P-1:0]   sx_sy, sx_sq;
    logic [W-1:0]   num_c, num_abs;
    logic [P-1:0]   den_c;

    assign xy = {{N{1'b0}}, i_samples_x_in}
              * {{N{1'b0}}, i_samples_y_in};
    assign xx = {{N{1'b0}}, i_samples_x_in}
              * {{N{1'b0}}, i_samples_x_in};

    assign sx_sy = {{AW{1'b0}}, sx_q} * {{AW{1'b0}}, sy_q};
    assign sx_sq = {{AW{1'b0}}, sx_q} * {{AW{1'b0}}, sx_q};

    // K*S is a shift by KW; NUM is signed, DEN is never negative.
    assign num_c = {1'b0, sxy_q, {KW{1'b0}}} - {1'b0, sx_sy};
    assign den_c = {sxx_q, {KW{1'b0}}} - sx_sq;
    assign num_abs = num_c[W-1] ? -num_c : num_c;

    // One restoring step: dq shifts dividend out, quotient in.
    logic [W-1:0] rem_sh, den_ext;
    logic         ge;

    assign rem_sh  = {rem_q, dq_q[W-1]};
    assign den_ext = {1'b0, den_q};
    assign ge      = (rem_sh >= den_ext);

    // Commit values; theta0 uses the already-narrowed theta1.
    logic signed [LW-1:0] q_s, t1_ext, sx_ext, sy_ext;
    logic signed [LW-1:0] prod, t0_full;
    logic [N-1:0]         theta1_c, theta0_c;

    assign q_s = neg_q ? -{1'b0, dq_q} : {1'b0, dq_q};
    assign theta1_c = reduce(q_s);
    assign t1_ext = {{(LW-N){theta1_c[N-1]}}, theta1_c};
    assign sx_ext = {{(LW-AW){1'b0}}, sx_q};
    assign sy_ext = {{(LW-AW){1'b0}}, sy_q};
    assign prod = t1_ext * sx_ext;
    assign t0_full = (sy_ext - prod) >>> KW;
    assign theta0_c = reduce(t0_full);

    always_comb begin
        state_d  = state_q;
        sx_d     = sx_q;
        sy_d     = sy_q;
        sxy_d    = sxy_q;
        sxx_d    = sxx_q;
        cnt_d    = cnt_q;
        den_d    = den_q;
        neg_d    = neg_q;
        dq_d     = dq_q;
        rem_d    = rem_q;
        dcnt_d   = dcnt_q;
        theta0_d = theta0_q;
        theta1_d = theta1_q;
        vld_d    = vld_q;
        done_d   = 1'b0;
        deg_d    = deg_q;

        unique case (state_q)
            ACCUM: begin
                if (i_samples_vld) begin
                    sx_d  = sx_q + {{KW{1'b0}}, i_samples_x_in};
                    sy_d  = sy_q + {{KW{1'b0}}, i_samples_y_in};
                    sxy_d = sxy_q + {{KW{1'b0}}, xy};
                    sxx_d = sxx_q + {{KW{1'b0}}, xx};
                    cnt_d = cnt_q + KW'(1);
                    if (cnt_q == {KW{1'b1}}) state_d = CALC;
                end
            end
            CALC: begin
                den_d  = den_c;
                neg_d  = num_c[W-1];
                rem_d  = '0;
                dcnt_d = '0;
                if (den_c == '0) begin
                    dq_d    = '0;
                    state_d = FINISH;
                end else begin
                    dq_d    = num_abs;
                    state_d = DIV;
                end
            end
            DIV: begin
                rem_d  = ge ? (W-1)'(rem_sh - den_ext)
                            : rem_sh[W-2:0];
                dq_d   = {dq_q[W-2:0], ge};
                dcnt_d = dcnt_q + CW'(1);
                if (dcnt_q == CW'(W - 1)) state_d = FINISH;
            end
            FINISH: begin
                theta1_d = theta1_c;
                theta0_d = theta0_c;
                deg_d    = (den_q == '0);
                vld_d    = 1'b1;
                done_d   = 1'b1;
                sx_d     = '0;
                sy_d     = '0;
                sxy_d    = '0;
                sxx_d    = '0;
                cnt_d    = '0;
                state_d  = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= ACCUM;
            sx_q     <= '0;
            sy_q     <= '0;
            sxy_q    <= '0;
            sxx_q    <= '0;
            cnt_q    <= '0;
            den_q    <= '0;
            neg_q    <= 1'b0;
            dq_q     <= '0;
            rem_q    <= '0;
            dcnt_q   <= '0;
            theta0_q <= '0;
            theta1_q <= '0;
            vld_q    <= 1'b0;
            done_q   <= 1'b0;
            deg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sx_q     <= sx_d;
            sy_q     <= sy_d;
            sxy_q    <= sxy_d;
            sxx_q    <= sxx_d;
            cnt_q    <= cnt_d;
            den_q    <= den_d;
            neg_q    <= neg_d;
            dq_q     <= dq_d;
            rem_q    <= rem_d;
            dcnt_q   <= dcnt_d;
            theta0_q <= theta0_d;
            theta1_q <= theta1_d;
            vld_q    <= vld_d;
            done_q   <= done_d;
            deg_q    <= deg_d;
        end
    end

    assign o_samples_rdy    = (state_q == ACCUM);
    assign o_theta0_out     = theta0_q;
    assign o_theta1_out     = theta1_q;
    assign o_theta1_out_vld = vld_q;
    assign o_train_done     = done_q;
    assign o_degenerate     = deg_q;

endmodule
